// File: rtl/ibex_pkg.sv
// Shared definitions for the instruction-bus arbiter: requester IDs and
// the arbiter lock state.
package ibex_pkg;

   typedef logic req_id_t;

   localparam req_id_t PREFETCH  = 1'b0;
   localparam req_id_t SECONDARY = 1'b1;

   typedef enum logic {
      ARB_FREE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/ibex_instr_arb_idfifo.sv
// In-order FIFO of granted requester IDs; the head names the owner of the
// next bus response.
module ibex_instr_arb_idfifo
   import ibex_pkg::*;
#(
   parameter int unsigned Depth = 2,
   localparam int unsigned CntW = $clog2(Depth + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic            push_id,
   input  logic            pop,
   output logic            head,
   output logic [CntW-1:0] count
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   req_id_t         mem [Depth];
   logic [PtrW-1:0] wr_ptr, rd_ptr;

   assign head = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_id;
            wr_ptr      <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
         end
         count <= count + CntW'(push) - CntW'(pop);
      end
   end

endmodule

// File: rtl/ibex_instr_bus_arbiter.sv
// Round-robin arbiter merging two instruction fetchers onto one in-order bus,
// with grant lock, outstanding-transaction limit and response routing.
module ibex_instr_bus_arbiter
   import ibex_pkg::*;
#(
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [1:0]       req_i,
   input  logic [1:0][31:0] addr_i,
   output logic [1:0]       gnt_o,
   output logic [1:0]       rvalid_o,
   output logic [31:0]      rdata_o,
   output logic             err_o,
   output logic             bus_req_o,
   output logic [31:0]      bus_addr_o,
   input  logic             bus_gnt_i,
   input  logic             bus_rvalid_i,
   input  logic [31:0]      bus_rdata_i,
   input  logic             bus_err_i,
   output logic             busy_o
);

   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

   arb_state_e      state_q, state_d;
   req_id_t         lock_id_q, lock_id_d;
   req_id_t         prio_q, prio_d;
   req_id_t         winner;
   req_id_t         head;
   logic            cand_req, full, pop, grant;
   logic [CntW-1:0] count;
   logic [31:0]     sel_addr;

   always_comb begin
      if (state_q == ARB_LOCKED) begin
         winner = lock_id_q;
      end else if (&req_i) begin
         winner = prio_q;
      end else begin
         winner = req_i[SECONDARY] ? SECONDARY : PREFETCH;
      end
   end

   assign cand_req = (state_q == ARB_LOCKED) ? req_i[lock_id_q] : |req_i;
   assign full     = (count == CntW'(MaxOutstanding));
   assign pop      = bus_rvalid_i & (count != '0);

   // A response in the same cycle frees a slot, so a full bus may still issue.
   assign bus_req_o  = rst_ni & cand_req & (~full | bus_rvalid_i);
   assign grant      = bus_req_o & bus_gnt_i;
   assign sel_addr   = addr_i[winner];
   assign bus_addr_o = sel_addr & 32'hFFFF_FFFC;
   assign gnt_o      = grant ? (2'b01 << winner) : 2'b00;

   assign rvalid_o = (rst_ni & pop) ? (2'b01 << head) : 2'b00;
   assign rdata_o  = bus_rdata_i;
   assign err_o    = bus_err_i;
   assign busy_o   = rst_ni & ((count != '0) | bus_req_o);

   ibex_instr_arb_idfifo #(
      .Depth(MaxOutstanding)
   ) u_idfifo (
      .clk    (clk_i),
      .rst_n  (rst_ni),
      .push   (grant),
      .push_id(winner),
      .pop    (pop),
      .head   (head),
      .count  (count)
   );

   always_comb begin
      state_d   = state_q;
      lock_id_d = lock_id_q;
      prio_d    = prio_q;
      if (grant) begin
         state_d = ARB_FREE;
         prio_d  = ~winner;
      end else if (bus_req_o) begin
         // Stalled by the bus: freeze the winner so the address stays stable.
         state_d   = ARB_LOCKED;
         lock_id_d = winner;
      end else if (state_q == ARB_LOCKED && !req_i[lock_id_q]) begin
         state_d = ARB_FREE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= ARB_FREE;
         lock_id_q <= PREFETCH;
         prio_q    <= PREFETCH;
      end else begin
         state_q   <= state_d;
         lock_id_q <= lock_id_d;
         prio_q    <= prio_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         assert (!(bus_rvalid_i && count == '0))
            else $warning("bus response with no outstanding transaction dropped");
         assert (!(state_q == ARB_LOCKED && !req_i[lock_id_q]))
            else $warning("locked requester withdrew its request before grant");
      end
   end

endmodule

// File: tb/tb_ibex_instr_bus_arbiter.sv
// Self-checking bench for ibex_instr_bus_arbiter: vector table, directed
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_ibex_instr_bus_arbiter;

   localparam int MAX = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       req;
   logic [1:0][31:0] addr;
   logic [1:0]       gnt, rvalid;
   logic [31:0]      rdata, bus_addr, bus_rdata;
   logic             err, bus_req, bus_gnt, bus_rvalid, bus_err, busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ibex_instr_bus_arbiter #(.MaxOutstanding(MAX)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_i       (req),
      .addr_i      (addr),
      .gnt_o       (gnt),
      .rvalid_o    (rvalid),
      .rdata_o     (rdata),
      .err_o       (err),
      .bus_req_o   (bus_req),
      .bus_addr_o  (bus_addr),
      .bus_gnt_i   (bus_gnt),
      .bus_rvalid_i(bus_rvalid),
      .bus_rdata_i (bus_rdata),
      .bus_err_i   (bus_err),
      .busy_o      (busy)
   );

   typedef struct {
      logic        rst;
      logic [1:0]  rq;
      logic [31:0] a0, a1;
      logic        g, rv;
      logic [31:0] rd;
      logic        er;
      logic [1:0]  e_gnt;
      logic        e_breq;
      logic [31:0] e_addr;
      logic [1:0]  e_rvo;
      logic        e_busy;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs after the falling edge, settle before sampling.
   task automatic step(input logic rst, input logic [1:0] rq, input logic [31:0] a0, a1,
                       input logic g, rv, input logic [31:0] rd, input logic er);
      @(negedge clk);
      rst_n = rst; req = rq; addr[0] = a0; addr[1] = a1;
      bus_gnt = g; bus_rvalid = rv; bus_rdata = rd; bus_err = er;
      #1;
   endtask

   task automatic idle(input logic rst, input logic rv);
      step(rst, 2'b00, 32'h0, 32'h0, 1'b0, rv, 32'h0, 1'b0);
   endtask

   initial begin
      logic [1:0]  pend;
      logic [31:0] pa [2];
      int          q [$];
      logic        prio, lk, lkid, w, g, rv, er, ebreq, ebusy;
      logic [31:0] rd;
      logic [1:0]  egnt, ervo;

      rst_n = 1'b0; req = '0; addr = '0;
      bus_gnt = 0; bus_rvalid = 0; bus_rdata = '0; bus_err = 0;

      tbl = '{
         '{0, 2'b11, 32'h100, 32'h300, 1, 1, 32'h0,        0, 2'b00, 0, 32'h0,   2'b00, 0},
         '{1, 2'b01, 32'h100, 32'h0,   1, 0, 32'h0,        0, 2'b01, 1, 32'h100, 2'b00, 1},
         '{1, 2'b00, 32'h0,   32'h0,   0, 0, 32'h0,        0, 2'b00, 0, 32'h0,   2'b00, 1},
         '{1, 2'b00, 32'h0,   32'h0,   0, 1, 32'hDEADBEEF, 0, 2'b00, 0, 32'h0,   2'b01, 1},
         '{1, 2'b00, 32'h0,   32'h0,   0, 0, 32'h0,        0, 2'b00, 0, 32'h0,   2'b00, 0},
         '{0, 2'b11, 32'h200, 32'h307, 1, 0, 32'h0,        0, 2'b00, 0, 32'h0,   2'b00, 0},
         '{1, 2'b11, 32'h200, 32'h307, 1, 0, 32'h0,        0, 2'b01, 1, 32'h200, 2'b00, 1},
         '{1, 2'b11, 32'h200, 32'h307, 1, 0, 32'h0,        0, 2'b10, 1, 32'h304, 2'b00, 1},
         '{1, 2'b11, 32'h200, 32'h307, 1, 1, 32'hA1,       0, 2'b01, 1, 32'h200, 2'b01, 1},
         '{1, 2'b11, 32'h200, 32'h307, 1, 1, 32'hA2,       1, 2'b10, 1, 32'h304, 2'b10, 1},
         '{1, 2'b00, 32'h0,   32'h0,   0, 1, 32'hA3,       0, 2'b00, 0, 32'h0,   2'b01, 1},
         '{1, 2'b00, 32'h0,   32'h0,   0, 1, 32'hA4,       0, 2'b00, 0, 32'h0,   2'b10, 1},
         '{1, 2'b00, 32'h0,   32'h0,   0, 0, 32'h0,        0, 2'b00, 0, 32'h0,   2'b00, 0}
      };

      for (int i = 0; i < 13; i++) begin
         step(tbl[i].rst, tbl[i].rq, tbl[i].a0, tbl[i].a1, tbl[i].g, tbl[i].rv, tbl[i].rd, tbl[i].er);
         chk($sformatf("vec%0d gnt", i), gnt, tbl[i].e_gnt);
         chk($sformatf("vec%0d bus_req", i), bus_req, tbl[i].e_breq);
         chk($sformatf("vec%0d rvalid", i), rvalid, tbl[i].e_rvo);
         chk($sformatf("vec%0d busy", i), busy, tbl[i].e_busy);
         if (tbl[i].e_breq) chk($sformatf("vec%0d bus_addr", i), bus_addr, tbl[i].e_addr);
         if (tbl[i].e_rvo != 0) chk($sformatf("vec%0d rdata_err", i), {rdata, err}, {tbl[i].rd, tbl[i].er});
      end

      // Lock: pointer favours requester 1, yet a stalled requester 0 keeps the bus.
      idle(0, 0);
      step(1, 2'b01, 32'h40, 32'h0, 1, 0, 32'h0, 0);
      chk("lock pre gnt", gnt, 2'b01);
      idle(1, 1);
      chk("lock pre drain", rvalid, 2'b01);
      for (int i = 0; i < 3; i++) begin
         step(1, 2'b01, 32'h500, 32'h600, 0, 0, 32'h0, 0);
         chk("lock stall", {gnt, bus_req, bus_addr}, {2'b00, 1'b1, 32'h500});
      end
      step(1, 2'b11, 32'h500, 32'h600, 0, 0, 32'h0, 0);
      chk("lock held vs prio", {gnt, bus_req, bus_addr}, {2'b00, 1'b1, 32'h500});
      step(1, 2'b11, 32'h500, 32'h600, 1, 0, 32'h0, 0);
      chk("lock grant", {gnt, bus_addr}, {2'b01, 32'h500});
      step(1, 2'b10, 32'h500, 32'h600, 1, 0, 32'h0, 0);
      chk("lock next", {gnt, bus_addr}, {2'b10, 32'h600});

      // Back-pressure at MaxOutstanding.
      idle(0, 0);
      step(1, 2'b11, 32'h10, 32'h20, 1, 0, 32'h0, 0);
      chk("bp gnt0", gnt, 2'b01);
      step(1, 2'b11, 32'h10, 32'h20, 1, 0, 32'h0, 0);
      chk("bp gnt1", gnt, 2'b10);
      step(1, 2'b11, 32'h10, 32'h20, 1, 0, 32'h0, 0);
      chk("bp full", {gnt, bus_req, busy}, {2'b00, 1'b0, 1'b1});
      step(1, 2'b11, 32'h10, 32'h20, 1, 1, 32'h55, 0);
      chk("bp rvalid frees", {gnt, bus_req, rvalid}, {2'b01, 1'b1, 2'b01});
      step(1, 2'b11, 32'h10, 32'h20, 1, 0, 32'h0, 0);
      chk("bp still full", bus_req, 1'b0);
      idle(1, 1);
      chk("bp drain1", rvalid, 2'b10);
      idle(1, 1);
      chk("bp drain2", rvalid, 2'b01);
      idle(1, 0);
      chk("bp idle", busy, 1'b0);

      // Same-cycle grant and response.
      idle(0, 0);
      step(1, 2'b10, 32'h0, 32'h80, 1, 0, 32'h0, 0);
      chk("same setup", gnt, 2'b10);
      step(1, 2'b01, 32'h90, 32'h0, 1, 1, 32'h77, 0);
      chk("same push+pop", {gnt, rvalid}, {2'b01, 2'b10});
      idle(1, 0);
      chk("same count1", busy, 1'b1);
      idle(1, 1);
      chk("same head0", rvalid, 2'b01);
      idle(1, 0);
      chk("same empty", busy, 1'b0);
      step(1, 2'b01, 32'hA0, 32'h0, 1, 1, 32'h0, 0);
      chk("empty push+rvalid", {gnt, rvalid}, {2'b01, 2'b00});
      idle(1, 1);
      chk("empty route later", rvalid, 2'b01);

      // Reset while transactions are outstanding.
      idle(0, 0);
      step(1, 2'b11, 32'h0, 32'h4, 1, 0, 32'h0, 0);
      step(1, 2'b11, 32'h0, 32'h4, 1, 0, 32'h0, 0);
      chk("rst two out", busy, 1'b1);
      idle(0, 0);
      idle(1, 1);
      chk("rst drop", {rvalid, busy}, {2'b00, 1'b0});

      // Randomized run against a queue-based model.
      idle(0, 0);
      pend = '0; pa[0] = '0; pa[1] = '0; prio = 0; lk = 0; lkid = 0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 2; i++)
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1; pa[i] = $urandom;
            end
         g  = 1'($urandom_range(0, 1));
         rv = (q.size() > 0) && ($urandom_range(0, 2) != 0);
         rd = $urandom;
         er = 1'($urandom_range(0, 1));
         if (lk) w = lkid;
         else if (pend == 2'b11) w = prio;
         else w = pend[1];
         ebreq = (pend != 0) && (q.size() < MAX || rv);
         egnt  = (ebreq && g) ? (w ? 2'b10 : 2'b01) : 2'b00;
         ervo  = rv ? ((q[0] == 1) ? 2'b10 : 2'b01) : 2'b00;
         ebusy = (q.size() > 0) || ebreq;
         step(1, pend, pa[0], pa[1], g, rv, rd, er);
         chk($sformatf("rand%0d ctl", c),
             {gnt, bus_req, rvalid, busy, bus_req ? bus_addr : 32'h0},
             {egnt, ebreq, ervo, ebusy, ebreq ? (pa[w] & 32'hFFFF_FFFC) : 32'h0});
         if (rv) chk($sformatf("rand%0d data", c), {rdata, err}, {rd, er});
         if (rv) void'(q.pop_front());
         if (egnt != 0) begin
            q.push_back(int'(w)); prio = ~w; lk = 0; pend[w] = 1'b0;
         end else if (ebreq) begin
            lk = 1; lkid = w;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ibex_instr_bus_arbiter.md
IBEX_INSTR_BUS_ARBITER -- requirements
Module: ibex_instr_bus_arbiter

Interface
REQ-001 Parameter MaxOutstanding, default 2: max granted-but-unanswered bus transactions, range 1..4.
REQ-002 Ports: one clock; reset is synchronous and active-low, named clk_i and rst_ni.
REQ-003 clk_i  input  1  clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  synchronous active-low reset.
REQ-005 req_i  input  2  per-requester request (bit 0 = prefetch buffer, bit 1 = secondary fetcher); held with addr stable until gnt_o.
REQ-006 addr_i  input  2x32  per-requester word address.
REQ-007 gnt_o  output  2  per-requester grant, combinational from bus_gnt_i.
REQ-008 rvalid_o  output  2  per-requester response valid.
REQ-009 rdata_o  output  32  response data, shared, valid with any rvalid_o bit.
REQ-010 err_o  output  1  response error, shared, valid with any rvalid_o bit.
REQ-011 bus_req_o / bus_addr_o  output  1 / 32  bus request and word-aligned address (bits 1:0 forced to 0).
REQ-012 bus_gnt_i / bus_rvalid_i / bus_rdata_i / bus_err_i  input  1 / 1 / 32 / 1  bus grant and in-order response.
REQ-013 busy_o  output  1  high while any transaction is outstanding or bus_req_o is high.

Function
REQ-014 Arbitration: round-robin with 1-bit priority pointer; a lone requester wins; on contention the pointer-selected requester wins.
REQ-015 Pointer update: on each bus grant, pointer moves to the non-granted requester.
REQ-016 Lock: when bus_req_o is high and bus_gnt_i is low, winner is registered and held, with bus_addr_o unchanged, until granted, even if the other requester has priority.
REQ-017 Locked winner dropping req_i before grant: lock released next cycle, no grant issued; this is a requester protocol violation and is flagged by an assertion.
REQ-018 Back-pressure: bus_req_o is forced low while outstanding count equals MaxOutstanding, unless bus_rvalid_i is high in the same cycle; gnt_o stays low.
REQ-019 gnt_o[w] = bus_req_o & bus_gnt_i & (winner == w); at most one bit high.
REQ-020 Ordering: ID FIFO of depth MaxOutstanding records the winner on every bus grant and pops on every bus_rvalid_i.
REQ-021 Response routing: rvalid_o[head ID] = bus_rvalid_i, other bit low; rdata_o/err_o pass bus_rdata_i/bus_err_i combinationally with zero latency.
REQ-022 Same-cycle grant and rvalid: push and pop both occur and count is unchanged; with an empty FIFO, the response is never routed to the new grant's ID.
REQ-023 bus_rvalid_i with empty FIFO: ignored, both rvalid_o bits low, assertion fires.
REQ-024 Counter width: $clog2(MaxOutstanding+1); count never exceeds MaxOutstanding and never underflows.
REQ-025 Request-to-bus latency: 0 cycles (combinational from req_i when unlocked).

Reset
REQ-026 On rst_ni low at a clock edge: count=0, FIFO empty, lock cleared, pointer=0 (requester 0 priority).
REQ-027 Reset outputs: bus_req_o=0, gnt_o=0, rvalid_o=0, busy_o=0; rdata_o and err_o unconstrained.
REQ-028 Reset mid-transaction: outstanding responses arriving after reset are dropped per REQ-023.

Structure
REQ-029 Shared package ibex_pkg holds the requester ID typedef (1 bit) and the requester index localparams (PREFETCH=0, SECONDARY=1).
REQ-030 One sub-module, ibex_instr_arb_idfifo, implements the ID FIFO: depth parameter, push/pop, head, count.

Verification
REQ-031 Single requester: req_i=01, addr 0x100, bus_gnt_i=1 same cycle -> gnt_o=01, bus_addr_o=0x100; rvalid 2 cycles later -> rvalid_o=01, rdata passed.
REQ-032 Contention: req_i=11 for 4 grants -> grant sequence 0,1,0,1; rvalids return in the same order and route to 0,1,0,1.
REQ-033 Lock: req_i=01 with gnt low 3 cycles, then req_i=11 -> requester 0 granted first, bus_addr_o stable all cycles.
REQ-034 Back-pressure, MaxOutstanding=2: two grants, no rvalid -> bus_req_o=0; rvalid arrives -> bus_req_o=1 that same cycle and grant accepted, count stays 2.
REQ-035 Same-cycle: count=1 (ID 1 pending), grant to 0 plus rvalid -> rvalid_o=10, count=1, head becomes 0.
REQ-036 Reset with 2 outstanding, then bus_rvalid_i=1 -> rvalid_o=00, busy_o=0, assertion logged.
